// File: rtl/camera_capture_writer_pkg.sv
// Shared types, colour constants and pixel helpers for the camera capture writer.
package camera_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitVsLow,
        StCapture
    } cap_state_t;

    localparam int unsigned DefHActive     = 640;
    localparam int unsigned DefVActive     = 480;
    localparam int unsigned DefFramePixels = 76800;

    localparam logic [11:0] ColWhite   = 12'hFFF;
    localparam logic [11:0] ColYellow  = 12'hFF0;
    localparam logic [11:0] ColCyan    = 12'h0FF;
    localparam logic [11:0] ColGreen   = 12'h0F0;
    localparam logic [11:0] ColMagenta = 12'hF0F;
    localparam logic [11:0] ColRed     = 12'hF00;
    localparam logic [11:0] ColBlue    = 12'h00F;
    localparam logic [11:0] ColBlack   = 12'h000;

    // Keep the top bits of each RGB565 field: R5[4:1], G6[5:2], B5[4:1].
    function automatic logic [11:0] rgb565_to_rgb444(input logic [7:0] b0, input logic [7:0] b1);
        return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    endfunction

    function automatic logic [11:0] colour_bar(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = ColWhite;
            3'd1:    c = ColYellow;
            3'd2:    c = ColCyan;
            3'd3:    c = ColGreen;
            3'd4:    c = ColMagenta;
            3'd5:    c = ColRed;
            3'd6:    c = ColBlue;
            default: c = ColBlack;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/camera_capture_writer_byte_pairer.sv
// Pairs camera bytes into pixels while href is high and converts RGB565 to RGB444.
module cam_byte_pairer
    import camera_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        href_i,
    input  logic [7:0]  data_i,
    output logic        pix_valid_o,
    output logic [11:0] pix_data_o
);

    logic       phase_q, phase_d;
    logic [7:0] b0_q, b0_d;

    always_comb begin
        phase_d = phase_q;
        b0_d    = b0_q;
        if (clr_i || !href_i) begin
            phase_d = 1'b0;
        end else begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                b0_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
            b0_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            b0_q    <= b0_d;
        end
    end

    assign pix_valid_o = href_i && phase_q && !clr_i;
    assign pix_data_o  = rgb565_to_rgb444(b0_q, data_i);

endmodule

// File: rtl/camera_capture_writer.sv
// OV7670 capture into the shared frame buffer with optional 2x2 decimation.
// Optional colour-bar source is enabled by defining CAPTURE_TESTPAT_EN.
module camera_capture_writer
    import camera_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DefHActive,
    parameter int unsigned V_ACTIVE     = DefVActive,
    parameter int unsigned DECIMATE     = 1,
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned FRAME_PIXELS = DefFramePixels
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              enable,
`ifdef CAPTURE_TESTPAT_EN
    input  logic              test_pattern,
`endif
    output logic [ADDR_W-1:0] wraddress,
    output logic [11:0]       wrdata,
    output logic              wren,
    output logic              frame_done,
    output logic              overflow
);

    // Column counter is at least 9 bits so the colour-bar index out_col[8:6] always exists.
    localparam int unsigned ColW = ($clog2(H_ACTIVE) + 2 > 9) ? $clog2(H_ACTIVE) + 2 : 9;
    localparam int unsigned RowW = $clog2(V_ACTIVE) + 2;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_PIXELS - 1);

    cap_state_t        state_q, state_d;
    logic              vsync_q, href_q;
    logic [ColW-1:0]   col_q, col_d, out_col_q, out_col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wraddr_q, wraddr_d;
    logic [11:0]       wrdata_q, wrdata_d, wr_pix, pix_data;
    logic              wren_q, wren_d, done_q, done_d, ovf_q, ovf_d;
    logic              pix_valid, start, keep, vs_rise, vs_fall, href_fall;

    assign vs_rise   = cam_vsync && !vsync_q;
    assign vs_fall   = !cam_vsync && vsync_q;
    assign href_fall = href_q && !cam_href;
    assign start     = (state_q == StWaitVsLow) && vs_fall && enable;
    assign keep      = (DECIMATE == 0) || (!col_q[0] && !row_q[0]);

    cam_byte_pairer u_pairer (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .clr_i       (start),
        .href_i      (cam_href),
        .data_i      (cam_data),
        .pix_valid_o (pix_valid),
        .pix_data_o  (pix_data)
    );

`ifdef CAPTURE_TESTPAT_EN
    assign wr_pix = test_pattern ? colour_bar(out_col_q[8:6]) : pix_data;
`else
    assign wr_pix = pix_data;
`endif

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        out_col_d = out_col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        wraddr_d  = wraddr_q;
        wrdata_d  = wrdata_q;
        wren_d    = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (cam_vsync) state_d = StWaitVsLow;
            end
            StWaitVsLow: begin
                if (start) begin
                    state_d   = StCapture;
                    col_d     = '0;
                    out_col_d = '0;
                    row_d     = '0;
                    addr_d    = '0;
                end
            end
            StCapture: begin
                // A vsync rise abandons whatever line is in flight.
                if (vs_rise) begin
                    state_d = StWaitVsLow;
                    done_d  = 1'b1;
                end else begin
                    if (pix_valid) begin
                        col_d = col_q + 1'b1;
                        if (keep) begin
                            out_col_d = out_col_q + 1'b1;
                            if (addr_q <= LastAddr) begin
                                wren_d   = 1'b1;
                                wraddr_d = addr_q;
                                wrdata_d = wr_pix;
                                addr_d   = addr_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    if (href_fall) begin
                        col_d     = '0;
                        out_col_d = '0;
                        row_d     = row_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= StIdle;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            col_q     <= '0;
            out_col_q <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            wraddr_q  <= '0;
            wrdata_q  <= '0;
            wren_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vsync_q   <= cam_vsync;
            href_q    <= cam_href;
            col_q     <= col_d;
            out_col_q <= out_col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            wraddr_q  <= wraddr_d;
            wrdata_q  <= wrdata_d;
            wren_q    <= wren_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wraddress  = wraddr_q;
    assign wrdata     = wrdata_q;
    assign wren       = wren_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_camera_capture_writer.sv
// Directed bench: a decimating 16x8 instance and a non-decimating instance share one camera stream.
module tb_camera_capture_writer;

    logic        clk = 1'b0;
    logic        rst_n, vsync, href, enable;
    logic [7:0]  data;
    logic        tp;
    logic [16:0] d_addr, a_addr;
    logic [11:0] d_data, a_data;
    logic        d_wren, a_wren, d_fd, a_fd, d_ovf, a_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_dec   = 0;
    int fd_all   = 0;
    logic [28:0] q_dec[$];
    logic [28:0] q_all[$];

    always #5 clk = ~clk;

    camera_capture_writer #(
        .H_ACTIVE(16), .V_ACTIVE(8), .DECIMATE(1), .ADDR_W(17), .FRAME_PIXELS(32)
    ) u_dec (
        .clk_clk(clk), .reset_reset_n(rst_n), .cam_vsync(vsync), .cam_href(href),
        .cam_data(data), .enable(enable),
`ifdef CAPTURE_TESTPAT_EN
        .test_pattern(tp),
`endif
        .wraddress(d_addr), .wrdata(d_data), .wren(d_wren), .frame_done(d_fd), .overflow(d_ovf)
    );

    camera_capture_writer #(
        .H_ACTIVE(16), .V_ACTIVE(8), .DECIMATE(0), .ADDR_W(17), .FRAME_PIXELS(256)
    ) u_all (
        .clk_clk(clk), .reset_reset_n(rst_n), .cam_vsync(vsync), .cam_href(href),
        .cam_data(data), .enable(enable),
`ifdef CAPTURE_TESTPAT_EN
        .test_pattern(tp),
`endif
        .wraddress(a_addr), .wrdata(a_data), .wren(a_wren), .frame_done(a_fd), .overflow(a_ovf)
    );

    always @(negedge clk) begin
        if (d_wren) q_dec.push_back({d_addr, d_data});
        if (a_wren) q_all.push_back({a_addr, a_data});
        if (d_fd) fd_dec++;
        if (a_fd) fd_all++;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic byte_out(input logic [7:0] b);
        href = 1'b1;
        data = b;
        tick();
    endtask

    task automatic href_low(input int n);
        href = 1'b0;
        data = 8'h00;
        repeat (n) tick();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    function automatic logic [11:0] conv(input logic [7:0] b0, input logic [7:0] b1);
        logic [3:0] r, g, b;
        r = b0[7:4];
        g = {b0[2:0], b1[7]};
        b = b1[4:1];
        return {r, g, b};
    endfunction

    function automatic logic [7:0] pb0(input int r, input int c);
        return {4'(r), 4'(c)};
    endfunction

    function automatic logic [7:0] pb1(input int r, input int c);
        return 8'(c * 37 + r * 11 + 5);
    endfunction

    task automatic send_frame(input int lines, input int pix);
        for (int r = 0; r < lines; r++) begin
            for (int c = 0; c < pix; c++) begin
                byte_out(pb0(r, c));
                byte_out(pb1(r, c));
            end
            href_low(2);
        end
    endtask

    task automatic clear_q();
        q_dec.delete();
        q_all.delete();
    endtask

    vec_t vecs[6];
    int   snap_d, snap_a;

    initial begin
        vecs[0] = '{8'hF8, 8'h00, 12'hF00};
        vecs[1] = '{8'h07, 8'hE0, 12'h0F0};
        vecs[2] = '{8'h00, 8'h1F, 12'h00F};
        vecs[3] = '{8'hFF, 8'hFF, 12'hFFF};
        vecs[4] = '{8'h12, 8'h34, 12'h14A};
        vecs[5] = '{8'hAB, 8'hCD, 12'hA76};

        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00; enable = 1'b1; tp = 1'b0;
        repeat (3) tick();
        check("reset_dec", {d_addr, d_data, d_wren, d_fd, d_ovf}, 32'h0);
        check("reset_all", {a_addr, a_data, a_wren, a_fd, a_ovf}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Conversion table, one write per pixel one cycle after its second byte.
        vsync_pulse();
        for (int i = 0; i < 6; i++) begin
            byte_out(vecs[i].b0);
            check("conv_no_early_wren", a_wren, 0);
            byte_out(vecs[i].b1);
            check("conv_wren", a_wren, 1);
            check("conv_data", a_data, vecs[i].exp);
            check("conv_addr", a_addr, i);
            check("dec_wren", d_wren, (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) begin
                check("dec_data", d_data, vecs[i].exp);
                check("dec_addr", d_addr, i / 2);
            end
        end
        href_low(2);

        // Full decimated frame fills the buffer exactly.
        snap_d = fd_dec;
        vsync_pulse();
        check("frame_done_conv", fd_dec, snap_d + 1);
        clear_q();
        send_frame(8, 16);
        check("full_count", q_dec.size(), 32);
        for (int i = 0; i < q_dec.size() && i < 32; i++) begin
            check("full_addr", q_dec[i][28:12], i);
            check("full_data", q_dec[i][11:0],
                  conv(pb0(2 * (i / 8), 2 * (i % 8)), pb1(2 * (i / 8), 2 * (i % 8))));
        end
        check("full_all_count", q_all.size(), 128);
        check("full_no_ovf", d_ovf, 0);
        snap_d = fd_dec;
        vsync_pulse();
        check("frame_done_full", fd_dec, snap_d + 1);

        // Extra rows run past the buffer end.
        clear_q();
        send_frame(10, 16);
        check("ovf_count", q_dec.size(), 32);
        if (q_dec.size() > 0) check("ovf_last_addr", q_dec[q_dec.size() - 1][28:12], 31);
        check("ovf_set", d_ovf, 1);
        vsync_pulse();
        clear_q();
        send_frame(2, 16);
        check("ovf_next_count", q_dec.size(), 8);
        if (q_dec.size() > 0) check("ovf_next_addr0", q_dec[0][28:12], 0);
        check("ovf_sticky", d_ovf, 1);

        // enable low at vsync fall skips the whole frame.
        vsync = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        vsync = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        clear_q();
        send_frame(2, 16);
        check("en_skip_dec", q_dec.size(), 0);
        check("en_skip_all", q_all.size(), 0);
        vsync_pulse();
        send_frame(2, 16);
        check("en_next_count", q_dec.size(), 8);
        if (q_dec.size() > 0) check("en_next_addr0", q_dec[0][28:12], 0);

        // Odd byte count drops the partial pixel; next line pairs from its first byte.
        vsync_pulse();
        clear_q();
        byte_out(8'hF8); byte_out(8'h00); byte_out(8'h07);
        href_low(2);
        byte_out(8'h00); byte_out(8'h1F); byte_out(8'hFF); byte_out(8'hFF);
        href_low(2);
        check("odd_all_count", q_all.size(), 3);
        if (q_all.size() == 3) begin
            check("odd_w0", q_all[0], {17'd0, 12'hF00});
            check("odd_w1", q_all[1], {17'd1, 12'h00F});
            check("odd_w2", q_all[2], {17'd2, 12'hFFF});
        end
        check("odd_dec_count", q_dec.size(), 1);

        // vsync rising mid-line still ends the frame.
        snap_d = fd_dec;
        snap_a = fd_all;
        byte_out(8'h12); byte_out(8'h34); byte_out(8'h56);
        vsync = 1'b1;
        byte_out(8'h78);
        href_low(2);
        vsync = 1'b0;
        repeat (2) tick();
        check("midline_fd_dec", fd_dec, snap_d + 1);
        check("midline_fd_all", fd_all, snap_a + 1);
        clear_q();
        send_frame(1, 4);
        check("midline_next_count", q_all.size(), 4);
        if (q_all.size() > 0) check("midline_next_addr0", q_all[0][28:12], 0);

        // Asynchronous reset mid-line.
        byte_out(8'hF8);
        byte_out(8'h00);
        check("pre_reset_wren", a_wren, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_dec", {d_addr, d_data, d_wren, d_fd, d_ovf}, 32'h0);
        check("midreset_all", {a_addr, a_data, a_wren, a_fd, a_ovf}, 32'h0);
        href_low(1);
        rst_n = 1'b1;
        tick();
        clear_q();
        send_frame(2, 4);
        check("post_reset_idle", q_all.size() + q_dec.size(), 0);
        vsync_pulse();
        send_frame(1, 4);
        check("post_reset_count", q_all.size(), 4);
        if (q_all.size() > 0) check("post_reset_addr0", q_all[0][28:12], 0);

`ifdef CAPTURE_TESTPAT_EN
        tp = 1'b1;
        vsync_pulse();
        clear_q();
        send_frame(1, 66);
        tp = 1'b0;
        check("tp_count", q_all.size(), 66);
        if (q_all.size() > 64) begin
            check("tp_col0", q_all[0][11:0], 12'hFFF);
            check("tp_col64", q_all[64][11:0], 12'hFF0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
